instr_fetch: RTL and testbench
==============================

Name: instr_fetch

Overview:
- Instruction fetch stage directly upstream of the decode/control FSM that drives register enables, operand muxes and ALU control.
- Holds the program counter and reads 16-bit instruction words from instruction memory over a request/acknowledge handshake.
- Presents each word, with its address, to decode over a valid/ready handshake.
- Supports jump/branch redirect from downstream and a halt input.

Parameters:
- ADDR_W, 16, width of PC and memory address (word-addressed).
- DATA_W, 16, instruction word width.
- RESET_PC, 0, PC value loaded on reset.

Ports:
- clk  input  1  system clock, all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- mem_addr  output  ADDR_W  instruction memory word address; equals pc.
- mem_rd  output  1  read request; held high until mem_ack.
- mem_rdata  input  DATA_W  read data; valid only in the cycle mem_ack=1.
- mem_ack  input  1  read complete; sampled only while mem_rd=1.
- instr  output  DATA_W  fetched instruction word to decode.
- instr_pc  output  ADDR_W  address instr was fetched from.
- instr_valid  output  1  instr/instr_pc valid.
- instr_ready  input  1  decode accepts instr this cycle.
- redirect  input  1  one-cycle pulse: load redirect_pc, flush held instruction.
- redirect_pc  input  ADDR_W  target address for redirect.
- halt  input  1  level: stop issuing new fetches.
- fetch_busy  output  1  high while a memory read is outstanding (state REQ).

Behaviour:
- Reset (async, immediate, any state including mid-read):
  - pc=RESET_PC, state=REQ.
  - instr=0, instr_pc=0, instr_valid=0.
  - mem_rd and fetch_busy are combinational from state and go high as soon as reset releases.
- States: REQ, HOLD, HALTED.
- REQ:
  - mem_rd=1, mem_addr=pc, fetch_busy=1.
  - Stays in REQ until mem_ack=1.
  - On ack: instr<=mem_rdata, instr_pc<=pc, pc<=pc+1, instr_valid<=1, next state HOLD.
  - Latency: ack in cycle N gives instr_valid=1 in cycle N+1.
- HOLD:
  - mem_rd=0. instr, instr_pc and instr_valid stay stable while instr_ready=0.
  - On instr_valid&&instr_ready: instr_valid<=0; next state HALTED if halt=1, otherwise REQ.
  - Throughput is 1 instruction per 2 cycles with zero-wait memory; no prefetch.
- HALTED:
  - mem_rd=0, instr_valid=0.
  - halt=0 → REQ on the next edge. Stays while halt=1.
- Halt is sampled only at the HOLD→REQ decision. A read in progress always completes and its instruction is delivered first.
- Redirect (highest priority, any state):
  - pc<=redirect_pc and instr_valid<=0; the held instruction is discarded even if instr_ready=1 that cycle.
  - Next state REQ if halt=0, HALTED if halt=1.
- Redirect in the same cycle as mem_ack:
  - Data is discarded; no instr_valid; pc<=redirect_pc, not pc+1.
  - mem_addr shows redirect_pc in the following cycle with mem_rd=1.
- PC arithmetic: pc+1 modulo 2^ADDR_W; 0xFFFF+1 wraps to 0x0000. No overflow flag.
- mem_rdata is ignored when mem_ack=0. mem_ack is ignored outside REQ.
- No combinational path from instr_ready or mem_ack to any output. All outputs are registered or decoded from state only.

Test Plan:
- Reset release, memory acks one cycle after every request with words 0x5002, 0x900A, 0x0020; instr_ready tied 1 → instr_valid pulses carry (0x5002,pc0), (0x900A,pc1), (0x0020,pc2), mem_addr steps 0,1,2,3.
- Memory ack delayed 3 cycles; instr_ready held 0 for 4 cycles after valid → mem_rd held high for 3 cycles with constant mem_addr; instr and instr_pc stable during backpressure; mem_rd=0 throughout HOLD.
- Redirect to 0x0040 while in REQ at pc=0x0005, and again same cycle as mem_ack → both times the ack data never appears; next mem_addr=0x0040; the following instr_pc=0x0040.
- Redirect while HOLD with instr_ready=1 the same cycle → instruction not consumed (instr_valid drops, no handshake counted); next fetch is from redirect_pc.
- halt=1 asserted during REQ → current instruction delivered, then HALTED with mem_rd=0 for 5 cycles; halt=0 → fetch resumes at next sequential pc.
- redirect_pc=0xFFFF, acks with 0xAAAA then 0xBBBB → instr_pc=0xFFFF, then 0x0000; reset asserted mid-REQ → outputs zero immediately, restart at RESET_PC.

Source files
------------

// File: rtl/instr_fetch.sv
// Instruction fetch stage: owns the PC, reads words over a req/ack memory port
// and hands each word with its address to decode over a valid/ready handshake.
module instr_fetch #(
    parameter int                ADDR_W   = 16,
    parameter int                DATA_W   = 16,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack,
    output logic [DATA_W-1:0] instr,
    output logic [ADDR_W-1:0] instr_pc,
    output logic              instr_valid,
    input  logic              instr_ready,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              halt,
    output logic              fetch_busy
);

    typedef enum logic [1:0] {
        S_REQ    = 2'd0,
        S_HOLD   = 2'd1,
        S_HALTED = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(1);

    state_t            state_reg, state_next;
    logic [ADDR_W-1:0] pc_reg, pc_next;
    logic [DATA_W-1:0] instr_reg, instr_next;
    logic [ADDR_W-1:0] instr_pc_reg, instr_pc_next;
    logic              valid_reg, valid_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= S_REQ;
            pc_reg       <= RESET_PC;
            instr_reg    <= '0;
            instr_pc_reg <= '0;
            valid_reg    <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            instr_reg    <= instr_next;
            instr_pc_reg <= instr_pc_next;
            valid_reg    <= valid_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        instr_next    = instr_reg;
        instr_pc_next = instr_pc_reg;
        valid_next    = valid_reg;

        // Redirect overrides everything, including an ack or a decode accept
        // landing in the same cycle.
        if (redirect) begin
            pc_next    = redirect_pc;
            valid_next = 1'b0;
            state_next = halt ? S_HALTED : S_REQ;
        end else begin
            case (state_reg)
                S_REQ: begin
                    if (mem_ack) begin
                        instr_next    = mem_rdata;
                        instr_pc_next = pc_reg;
                        pc_next       = pc_reg + PC_STEP;
                        valid_next    = 1'b1;
                        state_next    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (valid_reg && instr_ready) begin
                        valid_next = 1'b0;
                        state_next = halt ? S_HALTED : S_REQ;
                    end
                end
                S_HALTED: begin
                    valid_next = 1'b0;
                    if (!halt) begin
                        state_next = S_REQ;
                    end
                end
                default: begin
                    valid_next = 1'b0;
                    state_next = S_REQ;
                end
            endcase
        end
    end

    assign mem_rd      = (state_reg == S_REQ);
    assign fetch_busy  = (state_reg == S_REQ);
    assign mem_addr    = pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = valid_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch: each task drives a scenario and checks
// the fetch outputs against hand-computed values.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic        mem_ack;
    logic [15:0] instr;
    logic [15:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        halt;
    logic        fetch_busy;

    int n_checks = 0;
    int n_fail   = 0;

    instr_fetch #(.ADDR_W(16), .DATA_W(16), .RESET_PC(16'h0000)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_addr   (mem_addr),
        .mem_rd     (mem_rd),
        .mem_rdata  (mem_rdata),
        .mem_ack    (mem_ack),
        .instr      (instr),
        .instr_pc   (instr_pc),
        .instr_valid(instr_valid),
        .instr_ready(instr_ready),
        .redirect   (redirect),
        .redirect_pc(redirect_pc),
        .halt       (halt),
        .fetch_busy (fetch_busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; mem_ack = 1'b0; mem_rdata = '0; instr_ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0; halt = 1'b0;
        tick(); tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", instr_valid); end
        n_checks++; if (instr !== 16'h0) begin n_fail++; $display("FAIL rst_instr: got %h want 0000", instr); end
        n_checks++; if (instr_pc !== 16'h0) begin n_fail++; $display("FAIL rst_instr_pc: got %h want 0000", instr_pc); end
        n_checks++; if (mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mem_addr: got %h want 0000", mem_addr); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (mem_rd !== 1'b1) begin n_fail++; $display("FAIL rst_release_mem_rd: got %b want 1", mem_rd); end
        n_checks++; if (fetch_busy !== 1'b1) begin n_fail++; $display("FAIL rst_release_busy: got %b want 1", fetch_busy); end
        tick();
        $display("reset: released, mem_rd=%b mem_addr=%h", mem_rd, mem_addr);
    endtask

    task automatic test_sequential();
        logic [15:0] words [3];
        words[0] = 16'h5002; words[1] = 16'h900A; words[2] = 16'h0020;
        instr_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_addr !== 16'(i) || mem_rd !== 1'b1) begin n_fail++; $display("FAIL seq_req%0d: got addr=%h rd=%b want addr=%h rd=1", i, mem_addr, mem_rd, 16'(i)); end
            tick();
            mem_ack = 1'b1; mem_rdata = words[i];
            tick();
            mem_ack = 1'b0; mem_rdata = 16'hxxxx;
            n_checks++; if (instr_valid !== 1'b1 || instr !== words[i] || instr_pc !== 16'(i)) begin n_fail++; $display("FAIL seq_deliver%0d: got v=%b instr=%h pc=%h want v=1 instr=%h pc=%h", i, instr_valid, instr, instr_pc, words[i], 16'(i)); end
            n_checks++; if (mem_rd !== 1'b0) begin n_fail++; $display("FAIL seq_hold_rd%0d: got %b want 0", i, mem_rd); end
            $display("seq: instr=%h pc=%h", instr, instr_pc);
            tick();
            n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL seq_consumed%0d: got %b want 0", i, instr_valid); end
        end
        n_checks++; if (mem_addr !== 16'h0003) begin n_fail++; $display("FAIL seq_addr3: got %h want 0003", mem_addr); end
    endtask

    task automatic test_backpressure();
        instr_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0003) begin n_fail++; $display("FAIL bp_wait%0d: got rd=%b addr=%h want rd=1 addr=0003", i, mem_rd, mem_addr); end
            tick();
        end
        mem_ack = 1'b1; mem_rdata = 16'h1234;
        tick();
        mem_ack = 1'b0; mem_rdata = 16'hxxxx;
        for (int i = 0; i < 4; i++) begin
            n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234 || instr_pc !== 16'h0003 || mem_rd !== 1'b0) begin n_fail++; $display("FAIL bp_hold%0d: got v=%b instr=%h pc=%h rd=%b want v=1 instr=1234 pc=0003 rd=0", i, instr_valid, instr, instr_pc, mem_rd); end
            tick();
        end
        instr_ready = 1'b1;
        tick();
        n_checks++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0004 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL bp_release: got v=%b addr=%h rd=%b want v=0 addr=0004 rd=1", instr_valid, mem_addr, mem_rd); end
        $display("backpressure: held instr 1234 for 4 cycles, next addr=%h", mem_addr);
    endtask

    task automatic test_redirect_req();
        mem_ack = 1'b1; mem_rdata = 16'h4444;
        tick();
        mem_ack = 1'b0;
        tick();
        n_checks++; if (mem_addr !== 16'h0005) begin n_fail++; $display("FAIL redir_pre_addr: got %h want 0005", mem_addr); end
        redirect = 1'b1; redirect_pc = 16'h0040;
        tick();
        redirect = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0040 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL redir_req: got v=%b addr=%h rd=%b want v=0 addr=0040 rd=1", instr_valid, mem_addr, mem_rd); end
        redirect = 1'b1; mem_ack = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        redirect = 1'b0; mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0040 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL redir_ack: got v=%b addr=%h rd=%b want v=0 addr=0040 rd=1", instr_valid, mem_addr, mem_rd); end
        tick();
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("FAIL redir_ack_dropped: got %b want 0", instr_valid); end
        instr_ready = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'h7777;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h7777 || instr_pc !== 16'h0040) begin n_fail++; $display("FAIL redir_target: got v=%b instr=%h pc=%h want v=1 instr=7777 pc=0040", instr_valid, instr, instr_pc); end
        $display("redirect_req: delivered instr=%h pc=%h", instr, instr_pc);
    endtask

    task automatic test_redirect_hold();
        instr_ready = 1'b1; redirect = 1'b1; redirect_pc = 16'h0080;
        tick();
        redirect = 1'b0; instr_ready = 1'b0;
        n_checks++; if (instr_valid !== 1'b0 || mem_addr !== 16'h0080 || mem_rd !== 1'b1) begin n_fail++; $display("FAIL redir_hold: got v=%b addr=%h rd=%b want v=0 addr=0080 rd=1", instr_valid, mem_addr, mem_rd); end
        mem_ack = 1'b1; mem_rdata = 16'h8888;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h8888 || instr_pc !== 16'h0080) begin n_fail++; $display("FAIL redir_hold_next: got v=%b instr=%h pc=%h want v=1 instr=8888 pc=0080", instr_valid, instr, instr_pc); end
        instr_ready = 1'b1;
        tick();
        $display("redirect_hold: next fetch addr=%h", mem_addr);
    endtask

    task automatic test_halt();
        halt = 1'b1;
        tick();
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0081) begin n_fail++; $display("FAIL halt_req: got rd=%b addr=%h want rd=1 addr=0081", mem_rd, mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'h5555;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h5555 || instr_pc !== 16'h0081) begin n_fail++; $display("FAIL halt_deliver: got v=%b instr=%h pc=%h want v=1 instr=5555 pc=0081", instr_valid, instr, instr_pc); end
        tick();
        for (int i = 0; i < 5; i++) begin
            n_checks++; if (mem_rd !== 1'b0 || instr_valid !== 1'b0 || fetch_busy !== 1'b0) begin n_fail++; $display("FAIL halted%0d: got rd=%b v=%b busy=%b want 0/0/0", i, mem_rd, instr_valid, fetch_busy); end
            tick();
        end
        halt = 1'b0;
        tick();
        n_checks++; if (mem_rd !== 1'b1 || mem_addr !== 16'h0082) begin n_fail++; $display("FAIL halt_resume: got rd=%b addr=%h want rd=1 addr=0082", mem_rd, mem_addr); end
        $display("halt: resumed at addr=%h", mem_addr);
    endtask

    task automatic test_wrap();
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        tick();
        redirect = 1'b0;
        mem_ack = 1'b1; mem_rdata = 16'hAAAA;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr !== 16'hAAAA || instr_pc !== 16'hFFFF) begin n_fail++; $display("FAIL wrap_ffff: got instr=%h pc=%h want AAAA/FFFF", instr, instr_pc); end
        tick();
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("FAIL wrap_addr: got %h want 0000", mem_addr); end
        mem_ack = 1'b1; mem_rdata = 16'hBBBB;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr !== 16'hBBBB || instr_pc !== 16'h0000) begin n_fail++; $display("FAIL wrap_0000: got instr=%h pc=%h want BBBB/0000", instr, instr_pc); end
        tick();
        $display("wrap: pc wrapped, mem_addr=%h", mem_addr);
    endtask

    task automatic test_reset_mid();
        instr_ready = 1'b0;
        #2 reset = 1'b1;
        #1;
        n_checks++; if (instr_valid !== 1'b0 || instr !== 16'h0 || instr_pc !== 16'h0 || mem_addr !== 16'h0) begin n_fail++; $display("FAIL rst_mid: got v=%b instr=%h pc=%h addr=%h want all 0", instr_valid, instr, instr_pc, mem_addr); end
        #2 reset = 1'b0;
        tick();
        mem_ack = 1'b1; mem_rdata = 16'h1111;
        tick();
        mem_ack = 1'b0;
        n_checks++; if (instr_valid !== 1'b1 || instr !== 16'h1111 || instr_pc !== 16'h0000) begin n_fail++; $display("FAIL rst_restart: got v=%b instr=%h pc=%h want 1/1111/0000", instr_valid, instr, instr_pc); end
        $display("reset_mid: restart instr=%h pc=%h", instr, instr_pc);
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_backpressure();
        test_redirect_req();
        test_redirect_hold();
        test_halt();
        test_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
